axis_transmission_combiner_n: RTL and testbench
===============================================

Name: axis_transmission_combiner_n

Overview:
- Parametrised N-input lockstep word interleaver for AXI Stream.
- Each input is a lane of one wide transfer. One head word is taken from every lane to form a "group". The non-null words (tkeep != 0) of each group are emitted in ascending lane order on a single output stream.
- Sits downstream of lane splitters, ahead of the output port queues.
- Over the fixed 4-lane generation it adds:
  - a configurable lane count;
  - same-cycle skipping of null lanes;
  - correct tlast when several trailing lanes are null;
  - optional lane tlast-alignment checking.

Parameters:
- NUM_INPUTS, 4, number of input lanes (2..16).
- TDATA_WIDTH, 256, data width per lane and output.
- TUSER_WIDTH, 128, tuser width per lane and output.
- FIFO_DEPTH_BITS, 4, log2 depth of each input FIFO and the output FIFO.

Ports:
- axis_aclk  in  1  single clock.
- axis_reset  in  1  synchronous, active-high reset.
- axis_input_tdata  in  NUM_INPUTS*TDATA_WIDTH  lane i at bits [i*TDATA_WIDTH +: TDATA_WIDTH].
- axis_input_tkeep  in  NUM_INPUTS*TDATA_WIDTH/8  per-lane byte enables.
- axis_input_tuser  in  NUM_INPUTS*TUSER_WIDTH  per-lane sideband.
- axis_input_tvalid  in  NUM_INPUTS  per-lane valid.
- axis_input_tready  out  NUM_INPUTS  per-lane ready.
- axis_input_tlast  in  NUM_INPUTS  per-lane last.
- axis_combined_tdata  out  TDATA_WIDTH  output data.
- axis_combined_tkeep  out  TDATA_WIDTH/8  output keep.
- axis_combined_tuser  out  TUSER_WIDTH  output sideband.
- axis_combined_tvalid  out  1  output valid.
- axis_combined_tready  in  1  downstream ready.
- axis_combined_tlast  out  1  output last.
- lane_misalign_error  out  1  sticky tlast-misalignment flag (see Optional Feature).

Behaviour:
- Reset (axis_reset=1 at a clock edge):
  - all FIFOs flushed; pointer k=0; output register cleared.
  - axis_combined_tvalid=0; lane_misalign_error=0.
  - axis_input_tready is 0 during reset and returns to 1 the cycle after reset deasserts.
  - A reset mid-group discards any partially emitted group; no further words of it are output.
- Input side:
  - Each lane has a fallthrough FIFO of depth 2^FIFO_DEPTH_BITS.
  - tready[i] = ~nearly_full[i]; a word is written when tvalid[i] & tready[i].
- Output side:
  - Output fallthrough FIFO; axis_combined_tvalid = ~empty.
  - A word is popped on tvalid & tready.
  - Data/keep/user/last are held stable while tvalid=1 and tready=0.
- Scheduler, pointer k in 0..NUM_INPUTS-1:
  - Acts only when the output FIFO is not nearly full.
  - k==0 (group start): also requires every input FIFO non-empty; otherwise stall.
  - k>0: lanes k..N-1 are guaranteed non-empty, because only lanes below k were popped in this group.
  - j = lowest lane >= k whose head is non-null.
  - If j exists: pop lanes k..j in the same cycle; register lane j's data/keep/user into the output stage; next k = j+1, or 0 if j==N-1.
  - If no j exists: pop lanes k..N-1; write nothing; next k = 0.
  - Output tlast = tlast[j] & (all lanes above j have null heads).
- Throughput: one non-null word per cycle. Null lanes cost no extra cycles, except an all-null remainder, which costs one cycle.
- Latency: input handshake at cycle t gives axis_combined_tvalid no earlier than t+3 (FIFO fallthrough, then scheduler register, then output FIFO).
- A registered write into the output FIFO is never lost; the nearly_full margin absorbs the one in-flight word.
- Backpressure: with axis_combined_tready=0 held, inputs eventually deassert tready. No word is dropped or duplicated.

Optional Feature:
- Macro: COMBINER_TLAST_CHECK_EN.
- Defined:
  - At each group start, if the tlast bits of the lane heads are not all equal, lane_misalign_error sets.
  - It stays set until reset. Data flow is unaffected.
- Undefined: lane_misalign_error is tied to 0 and no check logic is built.

Test Plan:
- NUM_INPUTS=4; one group, words A,B,C,D all keep=all-ones, tlast=1 on all lanes -> output A,B,C,D in order; tlast only on D; 4 consecutive valid cycles.
- Group with lane 1 and lane 2 null, lane 0 tlast=1 -> output lane0, lane3; lane 3 ends up carrying tlast; the scheduler pointer jumps 1->3 with no idle cycle.
- Group with lanes 1..3 null, lane 0 tlast=1 -> single output word from lane 0 with tlast=1; lanes 1..3 popped in one cycle.
- Lane 2 has tvalid=0 for 5 cycles while lanes 0,1,3 hold words -> no output until lane 2 fills; afterwards order 0,1,2,3 is preserved.
- axis_combined_tready=0 for 64 cycles with all inputs streaming -> every axis_input_tready drops; after release, all words emerge in order with none lost.
- Lane tlast pattern 1,0,1,1 with COMBINER_TLAST_CHECK_EN -> lane_misalign_error=1 from the next cycle; remains 1 until axis_reset; without the macro it stays 0.

Source files
------------

// File: rtl/axis_transmission_combiner_n.sv
`default_nettype none
// ============================================================================
// Module      : axis_transmission_combiner_n
// Description : N-input lockstep word interleaver for AXI Stream. One head
//               word per lane forms a group; the non-null words of a group
//               (tkeep != 0) are emitted in ascending lane order on a single
//               output stream. Null lanes are skipped in the same cycle.
// Optional    : COMBINER_TLAST_CHECK_EN - when defined, builds a sticky
//               lane_misalign_error flag raised when lane head tlast bits
//               disagree at a group start. Otherwise the flag is tied to 0.
// Ports       : axis_aclk / axis_reset (sync, active-high)
//               axis_input_*    : NUM_INPUTS packed lanes (data/keep/user/
//                                 valid/ready/last)
//               axis_combined_* : single output stream
//               lane_misalign_error : sticky tlast misalignment flag
// Revision    : 1.0 - initial release
// ============================================================================

// Fallthrough FIFO: the head entry is visible on rd_data whenever not empty.
module axis_transmission_combiner_n_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             nearly_full
);
    localparam int                c_DEPTH = 1 << DEPTH_BITS;
    // One slot of margin so a write decided a cycle earlier always fits.
    localparam logic [DEPTH_BITS:0] c_NF_LEVEL = (DEPTH_BITS+1)'(c_DEPTH - 1);

    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  w_rd;

    assign w_rd        = rd_en & ~empty;
    assign empty       = (r_count == '0);
    assign nearly_full = (r_count >= c_NF_LEVEL);
    assign rd_data     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{DEPTH_BITS{1'b0}}, wr_en} - {{DEPTH_BITS{1'b0}}, w_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[r_wr_ptr] <= wr_data;
    end
endmodule

module axis_transmission_combiner_n #(
    parameter int NUM_INPUTS      = 4,
    parameter int TDATA_WIDTH     = 256,
    parameter int TUSER_WIDTH     = 128,
    parameter int FIFO_DEPTH_BITS = 4
) (
    input  logic                                axis_aclk,
    input  logic                                axis_reset,
    input  logic [NUM_INPUTS*TDATA_WIDTH-1:0]   axis_input_tdata,
    input  logic [NUM_INPUTS*TDATA_WIDTH/8-1:0] axis_input_tkeep,
    input  logic [NUM_INPUTS*TUSER_WIDTH-1:0]   axis_input_tuser,
    input  logic [NUM_INPUTS-1:0]               axis_input_tvalid,
    output logic [NUM_INPUTS-1:0]               axis_input_tready,
    input  logic [NUM_INPUTS-1:0]               axis_input_tlast,
    output logic [TDATA_WIDTH-1:0]              axis_combined_tdata,
    output logic [TDATA_WIDTH/8-1:0]            axis_combined_tkeep,
    output logic [TUSER_WIDTH-1:0]              axis_combined_tuser,
    output logic                                axis_combined_tvalid,
    input  logic                                axis_combined_tready,
    output logic                                axis_combined_tlast,
    output logic                                lane_misalign_error
);
    localparam int c_KEEP_W  = TDATA_WIDTH / 8;
    // Entry layout: {last, user, keep, data}
    localparam int c_ENTRY_W = TDATA_WIDTH + c_KEEP_W + TUSER_WIDTH + 1;
    localparam int c_K_W     = $clog2(NUM_INPUTS);

    logic                  r_ready_en;
    logic [NUM_INPUTS-1:0] w_in_empty;
    logic [NUM_INPUTS-1:0] w_in_nearly_full;
    logic [NUM_INPUTS-1:0] w_in_pop;
    logic [NUM_INPUTS-1:0] w_in_null;
    logic [NUM_INPUTS-1:0] w_in_last;
    logic [c_ENTRY_W-1:0]  w_in_head [NUM_INPUTS];

    logic                  w_out_nearly_full;
    logic                  w_out_empty;
    logic [c_ENTRY_W-1:0]  w_out_head;

    logic [c_K_W-1:0]      r_k;
    logic [c_K_W-1:0]      w_k_next;
    logic [c_K_W-1:0]      w_j;
    logic                  w_found;
    logic                  w_act;
    logic                  w_tail_null;
    logic [c_ENTRY_W-1:0]  w_sel_head;
    logic                  r_out_valid;
    logic [c_ENTRY_W-1:0]  r_out_entry;

    // Holds tready low through reset and for the edge that releases it.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) r_ready_en <= 1'b0;
        else            r_ready_en <= 1'b1;
    end

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
        logic w_wr;
        assign axis_input_tready[gi] = r_ready_en & ~w_in_nearly_full[gi];
        assign w_wr = axis_input_tvalid[gi] & axis_input_tready[gi];

        axis_transmission_combiner_n_fifo #(
            .WIDTH      (c_ENTRY_W),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_in_fifo (
            .clk         (axis_aclk),
            .rst         (axis_reset),
            .wr_en       (w_wr),
            .wr_data     ({axis_input_tlast[gi],
                           axis_input_tuser[gi*TUSER_WIDTH +: TUSER_WIDTH],
                           axis_input_tkeep[gi*c_KEEP_W +: c_KEEP_W],
                           axis_input_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH]}),
            .rd_en       (w_in_pop[gi]),
            .rd_data     (w_in_head[gi]),
            .empty       (w_in_empty[gi]),
            .nearly_full (w_in_nearly_full[gi])
        );

        assign w_in_null[gi] = ~|w_in_head[gi][TDATA_WIDTH +: c_KEEP_W];
        assign w_in_last[gi] = w_in_head[gi][c_ENTRY_W-1];
    end

    // Scheduler. At k==0 every lane must hold a head; at k>0 only lanes
    // below k were popped in this group, so lanes k..N-1 are still present.
    always_comb begin
        w_act       = ~w_out_nearly_full & ((r_k != '0) | ~|w_in_empty);
        w_found     = 1'b0;
        w_j         = '0;
        w_in_pop    = '0;
        w_tail_null = 1'b1;
        w_k_next    = '0;

        // Lowest non-null lane at or above k.
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if ((c_K_W'(i) >= r_k) && !w_in_null[i]) begin
                w_found = 1'b1;
                w_j     = c_K_W'(i);
            end
        end

        // Pop k..j (null lanes skipped together with j), or k..N-1 if none.
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if ((c_K_W'(i) >= r_k) && (!w_found || (c_K_W'(i) <= w_j)))
                w_in_pop[i] = w_act;
            if ((c_K_W'(i) > w_j) && !w_in_null[i])
                w_tail_null = 1'b0;
        end

        w_sel_head = w_in_head[w_j];

        if (w_found && (w_j != c_K_W'(NUM_INPUTS - 1)))
            w_k_next = w_j + c_K_W'(1);
    end

    // Output tlast is the selected lane's tlast only when every lane above
    // it is null, so the real last word of the group carries it.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_entry <= '0;
        end else begin
            r_out_valid <= w_act & w_found;
            if (w_act)
                r_k <= w_k_next;
            if (w_act && w_found)
                r_out_entry <= {w_in_last[w_j] & w_tail_null, w_sel_head[c_ENTRY_W-2:0]};
        end
    end

    axis_transmission_combiner_n_fifo #(
        .WIDTH      (c_ENTRY_W),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_out_fifo (
        .clk         (axis_aclk),
        .rst         (axis_reset),
        .wr_en       (r_out_valid),
        .wr_data     (r_out_entry),
        .rd_en       (axis_combined_tvalid & axis_combined_tready),
        .rd_data     (w_out_head),
        .empty       (w_out_empty),
        .nearly_full (w_out_nearly_full)
    );

    assign axis_combined_tvalid = ~w_out_empty;
    assign axis_combined_tdata  = w_out_head[TDATA_WIDTH-1:0];
    assign axis_combined_tkeep  = w_out_head[TDATA_WIDTH +: c_KEEP_W];
    assign axis_combined_tuser  = w_out_head[TDATA_WIDTH + c_KEEP_W +: TUSER_WIDTH];
    assign axis_combined_tlast  = w_out_head[c_ENTRY_W-1];

`ifdef COMBINER_TLAST_CHECK_EN
    logic r_misalign;
    always_ff @(posedge axis_aclk) begin
        if (axis_reset)
            r_misalign <= 1'b0;
        else if (w_act && (r_k == '0) && (|w_in_last) && !(&w_in_last))
            r_misalign <= 1'b1;
    end
    assign lane_misalign_error = r_misalign;
`else
    assign lane_misalign_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_transmission_combiner_n.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axis_transmission_combiner_n
// Description : Scoreboard bench for axis_transmission_combiner_n (4 lanes).
//               Stimulus pushes lane words and hand-derived expected output
//               words; a monitor pops and compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_transmission_combiner_n;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int UW = 8;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } word_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] in_tdata;
    logic [N*KW-1:0] in_tkeep;
    logic [N*UW-1:0] in_tuser;
    logic [N-1:0]    in_tvalid;
    logic [N-1:0]    in_tready;
    logic [N-1:0]    in_tlast;
    logic [DW-1:0]   out_tdata;
    logic [KW-1:0]   out_tkeep;
    logic [UW-1:0]   out_tuser;
    logic            out_tvalid;
    logic            out_tready;
    logic            out_tlast;
    logic            misalign;

    always #5 clk = ~clk;

    axis_transmission_combiner_n #(
        .NUM_INPUTS(N), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .FIFO_DEPTH_BITS(4)
    ) dut (
        .axis_aclk            (clk),
        .axis_reset           (rst),
        .axis_input_tdata     (in_tdata),
        .axis_input_tkeep     (in_tkeep),
        .axis_input_tuser     (in_tuser),
        .axis_input_tvalid    (in_tvalid),
        .axis_input_tready    (in_tready),
        .axis_input_tlast     (in_tlast),
        .axis_combined_tdata  (out_tdata),
        .axis_combined_tkeep  (out_tkeep),
        .axis_combined_tuser  (out_tuser),
        .axis_combined_tvalid (out_tvalid),
        .axis_combined_tready (out_tready),
        .axis_combined_tlast  (out_tlast),
        .lane_misalign_error  (misalign)
    );

    word_t        lane_q [N][$];
    word_t        sb [$];
    int           out_cycle [$];
    logic [N-1:0] lane_block;
    int           cyc;
    int           n_cmp;
    int           n_bad;
    word_t        m_got;
    word_t        m_exp;
    logic [N-1:0] fire;
    int           mark;
    logic         exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic word_t mk(input int tag, input logic [KW-1:0] keep, input logic last);
        word_t w;
        w.data = 32'hC000_0000 | 32'(tag);
        w.keep = keep;
        w.user = 8'(tag);
        w.last = last;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    function automatic int pending();
        int s;
        s = sb.size();
        for (int i = 0; i < N; i++) s += lane_q[i].size();
        return s;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int t;
        t = 0;
        while (pending() != 0 && t < budget) begin
            tick();
            t++;
        end
        if (t >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout remaining=%0d required=0", name, pending());
        end
        repeat (5) tick();
    endtask

    // Lane drivers: a handshake is decided at the negedge before the edge.
    initial begin
        in_tvalid = '0;
        in_tdata  = '0;
        in_tkeep  = '0;
        in_tuser  = '0;
        in_tlast  = '0;
        forever begin
            @(negedge clk);
            fire = in_tvalid & in_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
                if (lane_q[i].size() > 0 && !lane_block[i] && !rst) begin
                    in_tdata[i*DW +: DW] = lane_q[i][0].data;
                    in_tkeep[i*KW +: KW] = lane_q[i][0].keep;
                    in_tuser[i*UW +: UW] = lane_q[i][0].user;
                    in_tlast[i]          = lane_q[i][0].last;
                    in_tvalid[i]         = 1'b1;
                end else begin
                    in_tvalid[i] = 1'b0;
                end
            end
        end
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst && out_tvalid && out_tready) begin
            m_got.data = out_tdata;
            m_got.keep = out_tkeep;
            m_got.user = out_tuser;
            m_got.last = out_tlast;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_word got data=%h user=%h last=%b required=none",
                         m_got.data, m_got.user, m_got.last);
            end else begin
                m_exp = sb.pop_front();
                if (m_got !== m_exp) begin
                    n_bad++;
                    $display("FAIL sb_word got data=%h keep=%h user=%h last=%b required data=%h keep=%h user=%h last=%b",
                             m_got.data, m_got.keep, m_got.user, m_got.last,
                             m_exp.data, m_exp.keep, m_exp.user, m_exp.last);
                end
            end
            out_cycle.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

`ifdef COMBINER_TLAST_CHECK_EN
    assign exp_err = 1'b1;
`else
    assign exp_err = 1'b0;
`endif

    initial begin
        cyc        = 0;
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        out_tready = 1'b1;
        lane_block = '0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_tvalid", 32'(out_tvalid), 0);
        check("rst_tready", 32'(in_tready), 0);
        check("rst_error", 32'(misalign), 0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_tready", 32'(in_tready), 32'hF);

        // 1: full group, tlast only on lane 3 output, 4 back-to-back words
        for (int i = 0; i < N; i++) lane_q[i].push_back(mk(16 + i, 4'hF, 1'b1));
        sb.push_back(mk(16, 4'hF, 1'b0));
        sb.push_back(mk(17, 4'hF, 1'b0));
        sb.push_back(mk(18, 4'hF, 1'b0));
        sb.push_back(mk(19, 4'hF, 1'b1));
        mark = out_cycle.size();
        wait_drain("t1", 200);
        check("t1_burst_span", 32'(out_cycle[mark+3] - out_cycle[mark]), 3);

        // 2: lanes 1,2 null -> lane0 then lane3 with no idle cycle
        lane_q[0].push_back(mk(32, 4'hF, 1'b1));
        lane_q[1].push_back(mk(33, 4'h0, 1'b1));
        lane_q[2].push_back(mk(34, 4'h0, 1'b1));
        lane_q[3].push_back(mk(35, 4'hF, 1'b1));
        sb.push_back(mk(32, 4'hF, 1'b0));
        sb.push_back(mk(35, 4'hF, 1'b1));
        mark = out_cycle.size();
        wait_drain("t2", 200);
        check("t2_gap", 32'(out_cycle[mark+1] - out_cycle[mark]), 1);

        // 3: lanes 1..3 null, then a group with null lanes 0 and 3 and
        //    partial keeps; trailing null lane 3 moves tlast onto lane 2
        lane_q[0].push_back(mk(48, 4'hF, 1'b1));
        lane_q[1].push_back(mk(49, 4'h0, 1'b1));
        lane_q[2].push_back(mk(50, 4'h0, 1'b1));
        lane_q[3].push_back(mk(51, 4'h0, 1'b1));
        lane_q[0].push_back(mk(52, 4'h0, 1'b1));
        lane_q[1].push_back(mk(53, 4'h3, 1'b1));
        lane_q[2].push_back(mk(54, 4'h8, 1'b1));
        lane_q[3].push_back(mk(55, 4'h0, 1'b1));
        sb.push_back(mk(48, 4'hF, 1'b1));
        sb.push_back(mk(53, 4'h3, 1'b0));
        sb.push_back(mk(54, 4'h8, 1'b1));
        mark = out_cycle.size();
        wait_drain("t3", 200);
        check("t3_null_tail_gap", 32'(out_cycle[mark+1] - out_cycle[mark]), 2);

        // 4: lane 2 starved -> nothing emitted until it delivers
        lane_block = 4'b0100;
        for (int i = 0; i < N; i++) lane_q[i].push_back(mk(64 + i, 4'hF, 1'b1));
        for (int i = 0; i < N; i++) sb.push_back(mk(64 + i, 4'hF, 1'(i == 3)));
        mark = out_cycle.size();
        repeat (8) tick();
        check("t4_stalled_outputs", 32'(out_cycle.size() - mark), 0);
        lane_block = '0;
        wait_drain("t4", 200);
        check("t4_outputs", 32'(out_cycle.size() - mark), 4);
        check("t4_error_clear", 32'(misalign), 0);

        // 5: 64 cycles of output backpressure with all lanes streaming
        out_tready = 1'b0;
        for (int g = 0; g < 30; g++)
            for (int i = 0; i < N; i++) begin
                lane_q[i].push_back(mk(100 + g * 4 + i, 4'hF, 1'b1));
                sb.push_back(mk(100 + g * 4 + i, 4'hF, 1'(i == 3)));
            end
        repeat (64) tick();
        @(negedge clk);
        check("t5_tready_low", 32'(in_tready), 0);
        check("t5_tvalid_held", 32'(out_tvalid), 1);
        check("t5_head_held", out_tdata, 32'hC000_0064);
        tick();
        out_tready = 1'b1;
        wait_drain("t5", 2000);

        // 6: misaligned tlast 1,0,1,1
        lane_q[0].push_back(mk(200, 4'hF, 1'b1));
        lane_q[1].push_back(mk(201, 4'hF, 1'b0));
        lane_q[2].push_back(mk(202, 4'hF, 1'b1));
        lane_q[3].push_back(mk(203, 4'hF, 1'b1));
        sb.push_back(mk(200, 4'hF, 1'b0));
        sb.push_back(mk(201, 4'hF, 1'b0));
        sb.push_back(mk(202, 4'hF, 1'b0));
        sb.push_back(mk(203, 4'hF, 1'b1));
        wait_drain("t6", 200);
        check("t6_error", 32'(misalign), 32'(exp_err));
        for (int i = 0; i < N; i++) lane_q[i].push_back(mk(210 + i, 4'hF, 1'b1));
        for (int i = 0; i < N; i++) sb.push_back(mk(210 + i, 4'hF, 1'(i == 3)));
        wait_drain("t6b", 200);
        check("t6_error_sticky", 32'(misalign), 32'(exp_err));

        // 7: reset with words in flight discards them and clears the flag
        out_tready = 1'b0;
        for (int i = 0; i < N; i++) lane_q[i].push_back(mk(220 + i, 4'hF, 1'b1));
        repeat (10) tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) lane_q[i].delete();
        sb.delete();
        tick();
        @(negedge clk);
        check("t7_rst_tvalid", 32'(out_tvalid), 0);
        check("t7_rst_tready", 32'(in_tready), 0);
        check("t7_rst_error", 32'(misalign), 0);
        tick();
        rst = 1'b0;
        out_tready = 1'b1;
        mark = out_cycle.size();
        tick();
        @(negedge clk);
        check("t7_tready_back", 32'(in_tready), 32'hF);
        repeat (10) tick();
        check("t7_no_output", 32'(out_cycle.size() - mark), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
